// File: rtl/rle_run_filter_if.sv
// Pixel-stream / line-record bundle for the run-length filter.
//   master: drives pix_valid, pix, sol; receives the per-line record.
//   slave : consumes the pixel stream; drives out_valid, run_found, run_start,
//           run_len, line_idx, sync_err.
interface rle_run_filter_if #(
  parameter int unsigned X_W    = 10,
  parameter int unsigned LINE_W = 10
);

  logic              pix_valid;
  logic              pix;
  logic              sol;
  logic              out_valid;
  logic              run_found;
  logic [X_W-1:0]    run_start;
  logic [X_W:0]      run_len;
  logic [LINE_W-1:0] line_idx;
  logic              sync_err;

  modport master (
    output pix_valid, pix, sol,
    input  out_valid, run_found, run_start, run_len, line_idx, sync_err
  );

  modport slave (
    input  pix_valid, pix, sol,
    output out_valid, run_found, run_start, run_len, line_idx, sync_err
  );

endinterface

// File: rtl/rle_run_filter.sv
// Per-line longest-run filter for a binary mask stream. Bridges inactive gaps
// of up to GAP_TOL pixels, keeps the earliest longest run of each line and
// emits one record per line, suppressing runs shorter than MIN_SIZE.
// Ports:
//   CLK     - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - slave modport: pixel stream in (pix_valid/pix/sol),
//             line record out (out_valid/run_found/run_start/run_len/
//             line_idx/sync_err)
module rle_run_filter #(
  parameter int unsigned IMAGE_W  = 640,
  parameter int unsigned X_W      = 10,
  parameter int unsigned MIN_SIZE = 5,
  parameter int unsigned GAP_TOL  = 0,
  parameter logic        ACTIVE   = 1'b1,
  parameter int unsigned LINE_W   = 10
) (
  input  logic             CLK,
  input  logic             reset_n,
  rle_run_filter_if.slave  bus
);

  localparam int unsigned LEN_W = X_W + 1;

  localparam logic [X_W-1:0]   X_LAST    = X_W'(IMAGE_W - 1);
  localparam logic [LEN_W-1:0] GAP_CLOSE = LEN_W'(GAP_TOL + 1);
  localparam logic [LEN_W-1:0] MIN_LEN   = LEN_W'(MIN_SIZE);

  // Per-line tracking state
  logic [X_W-1:0]    x_q,        x_d;
  logic              in_run_q,   in_run_d;
  logic [X_W-1:0]    cur_s_q,    cur_s_d;
  logic [LEN_W-1:0]  cur_len_q,  cur_len_d;
  logic [LEN_W-1:0]  gap_q,      gap_d;
  logic [X_W-1:0]    best_s_q,   best_s_d;
  logic [LEN_W-1:0]  best_len_q, best_len_d;
  logic [LINE_W-1:0] line_q,     line_d;

  // Registered record outputs
  logic              out_valid_q, out_valid_d;
  logic              run_found_q, run_found_d;
  logic [X_W-1:0]    run_start_q, run_start_d;
  logic [LEN_W-1:0]  run_len_q,   run_len_d;
  logic [LINE_W-1:0] line_idx_q,  line_idx_d;
  logic              sync_err_q,  sync_err_d;

  logic restart_c;
  logic close_c;
  logic eol_c;

  // Next-state: resync, run tracking, run close/compare, end-of-line record
  always_comb begin
    x_d         = x_q;
    in_run_d    = in_run_q;
    cur_s_d     = cur_s_q;
    cur_len_d   = cur_len_q;
    gap_d       = gap_q;
    best_s_d    = best_s_q;
    best_len_d  = best_len_q;
    line_d      = line_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    run_found_d = run_found_q;
    run_start_d = run_start_q;
    run_len_d   = run_len_q;
    line_idx_d  = line_idx_q;
    restart_c   = 1'b0;
    close_c     = 1'b0;
    eol_c       = 1'b0;

    if (bus.pix_valid) begin
      // sol mid-line: drop the partial line and treat this pixel as x=0
      restart_c = bus.sol && (x_q != '0);
      if (restart_c) begin
        x_d        = '0;
        in_run_d   = 1'b0;
        cur_s_d    = '0;
        cur_len_d  = '0;
        gap_d      = '0;
        best_s_d   = '0;
        best_len_d = '0;
        sync_err_d = 1'b1;
      end

      if (bus.pix == ACTIVE) begin
        if (!in_run_d) begin
          in_run_d  = 1'b1;
          cur_s_d   = x_d;
          cur_len_d = LEN_W'(1);
        end else begin
          // Pending gap pixels become part of the run
          cur_len_d = cur_len_d + gap_d + LEN_W'(1);
        end
        gap_d = '0;
      end else if (in_run_d) begin
        gap_d = gap_d + LEN_W'(1);
        if (gap_d == GAP_CLOSE) close_c = 1'b1;
      end

      eol_c = (x_d == X_LAST);
      if (eol_c && in_run_d) close_c = 1'b1;

      // Strict compare keeps the earliest run on ties
      if (close_c) begin
        if (cur_len_d > best_len_d) begin
          best_s_d   = cur_s_d;
          best_len_d = cur_len_d;
        end
        in_run_d = 1'b0;
        gap_d    = '0;
      end

      if (eol_c) begin
        out_valid_d = 1'b1;
        line_idx_d  = line_q;
        line_d      = line_q + LINE_W'(1);
        if (best_len_d >= MIN_LEN) begin
          run_found_d = 1'b1;
          run_start_d = best_s_d;
          run_len_d   = best_len_d;
        end else begin
          run_found_d = 1'b0;
          run_start_d = '0;
          run_len_d   = '0;
        end
        x_d        = '0;
        in_run_d   = 1'b0;
        cur_s_d    = '0;
        cur_len_d  = '0;
        gap_d      = '0;
        best_s_d   = '0;
        best_len_d = '0;
      end else begin
        x_d = x_d + X_W'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      in_run_q    <= 1'b0;
      cur_s_q     <= '0;
      cur_len_q   <= '0;
      gap_q       <= '0;
      best_s_q    <= '0;
      best_len_q  <= '0;
      line_q      <= '0;
      out_valid_q <= 1'b0;
      run_found_q <= 1'b0;
      run_start_q <= '0;
      run_len_q   <= '0;
      line_idx_q  <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      x_q         <= x_d;
      in_run_q    <= in_run_d;
      cur_s_q     <= cur_s_d;
      cur_len_q   <= cur_len_d;
      gap_q       <= gap_d;
      best_s_q    <= best_s_d;
      best_len_q  <= best_len_d;
      line_q      <= line_d;
      out_valid_q <= out_valid_d;
      run_found_q <= run_found_d;
      run_start_q <= run_start_d;
      run_len_q   <= run_len_d;
      line_idx_q  <= line_idx_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.run_found = run_found_q;
  assign bus.run_start = run_start_q;
  assign bus.run_len   = run_len_q;
  assign bus.line_idx  = line_idx_q;
  assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_rle_run_filter.sv
// Directed bench for rle_run_filter with a 16-pixel line, MIN_SIZE=3,
// GAP_TOL=1. Line patterns are written with pixel 0 as the leftmost bit.
module tb_rle_run_filter;

  localparam int unsigned IMAGE_W = 16;
  localparam int unsigned X_W     = 4;
  localparam int unsigned LINE_W  = 10;

  logic CLK;
  logic reset_n;

  int checks = 0;
  int errors = 0;

  rle_run_filter_if #(.X_W(X_W), .LINE_W(LINE_W)) bus ();

  rle_run_filter #(
    .IMAGE_W (IMAGE_W),
    .X_W     (X_W),
    .MIN_SIZE(3),
    .GAP_TOL (1),
    .ACTIVE  (1'b1),
    .LINE_W  (LINE_W)
  ) dut (
    .CLK    (CLK),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // One idle (pix_valid low) cycle with garbage on pix/sol
  task automatic idle_cycle();
    bus.pix_valid = 1'b0;
    bus.pix       = 1'($urandom);
    bus.sol       = 1'($urandom);
    @(posedge CLK); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_out_valid: got %b want 0", bus.out_valid);
    end
  endtask

  // One accepted pixel; out_valid after the edge must equal exp_rec
  task automatic send_pixel(input logic p, input logic s, input logic exp_rec);
    bus.pix_valid = 1'b1;
    bus.pix       = p;
    bus.sol       = s;
    @(posedge CLK); #1;
    checks++;
    if (bus.out_valid !== exp_rec) begin
      errors++;
      $display("FAIL out_valid_timing: got %b want %b", bus.out_valid, exp_rec);
    end
  endtask

  task automatic send_partial(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) send_pixel(bits[15-i], i == 0, 1'b0);
  endtask

  // Full line; returns record and sync_err seen after pixels 0 and 1
  task automatic send_line(input logic [15:0] bits, input bit gaps,
                           output logic f, output logic [3:0] s,
                           output logic [4:0] l, output logic [9:0] idx,
                           output logic se0, output logic se1);
    se0 = 1'b0;
    se1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (gaps && (i % 3 == 1)) idle_cycle();
      send_pixel(bits[15-i], i == 0, i == 15);
      if (i == 0) se0 = bus.sync_err;
      if (i == 1) se1 = bus.sync_err;
    end
    f   = bus.run_found;
    s   = bus.run_start;
    l   = bus.run_len;
    idx = bus.line_idx;
  endtask

  task automatic test_reset();
    bus.pix_valid = 1'b0;
    bus.pix       = 1'b0;
    bus.sol       = 1'b0;
    reset_n       = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({bus.out_valid, bus.run_found, bus.sync_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {bus.out_valid, bus.run_found, bus.sync_err});
    end
    checks++;
    if (bus.run_start !== 4'd0 || bus.run_len !== 5'd0 || bus.line_idx !== 10'd0) begin
      errors++;
      $display("FAIL reset_fields: got start=%0d len=%0d idx=%0d want 0/0/0",
               bus.run_start, bus.run_len, bus.line_idx);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_lines();
    logic [15:0] pat  [9];
    logic        ef   [9];
    logic [3:0]  es   [9];
    logic [4:0]  el   [9];
    logic f, se0, se1;
    logic [3:0] s;
    logic [4:0] l;
    logic [9:0] idx;
    pat[0] = 16'b0000111100000000; ef[0] = 1; es[0] = 4;  el[0] = 4;
    pat[1] = 16'b0011011100000000; ef[1] = 1; es[1] = 2;  el[1] = 6;
    pat[2] = 16'b0011001110000000; ef[2] = 1; es[2] = 6;  el[2] = 3;
    pat[3] = 16'b1110000111000000; ef[3] = 1; es[3] = 0;  el[3] = 3;
    pat[4] = 16'b0000000000001111; ef[4] = 1; es[4] = 12; el[4] = 4;
    pat[5] = 16'b1111111111111111; ef[5] = 1; es[5] = 0;  el[5] = 16;
    pat[6] = 16'b0110000000000000; ef[6] = 0; es[6] = 0;  el[6] = 0;
    pat[7] = 16'b0000000000011110; ef[7] = 1; es[7] = 11; el[7] = 4;
    pat[8] = 16'b0000000000001101; ef[8] = 1; es[8] = 12; el[8] = 4;
    for (int k = 0; k < 9; k++) begin
      send_line(pat[k], 1'b0, f, s, l, idx, se0, se1);
      checks++;
      if (f !== ef[k] || s !== es[k] || l !== el[k]) begin
        errors++;
        $display("FAIL line%0d_record: got found=%b start=%0d len=%0d want found=%b start=%0d len=%0d",
                 k, f, s, l, ef[k], es[k], el[k]);
      end
      checks++;
      if (idx !== 10'(k)) begin
        errors++;
        $display("FAIL line%0d_idx: got %0d want %0d", k, idx, k);
      end
      checks++;
      if (se0 !== 1'b0) begin
        errors++;
        $display("FAIL line%0d_sync_err: got %b want 0", k, se0);
      end
    end
  endtask

  task automatic test_sync();
    logic f, se0, se1;
    logic [3:0] s;
    logic [4:0] l;
    logic [9:0] idx;
    send_partial(16'hFFFF, 7);
    send_line(16'b0000111100000000, 1'b0, f, s, l, idx, se0, se1);
    checks++;
    if (se0 !== 1'b1 || se1 !== 1'b0) begin
      errors++;
      $display("FAIL sync_err_pulse: got %b%b want 10", se0, se1);
    end
    checks++;
    if (f !== 1'b1 || s !== 4'd4 || l !== 5'd4) begin
      errors++;
      $display("FAIL sync_record: got found=%b start=%0d len=%0d want 1/4/4", f, s, l);
    end
    checks++;
    if (idx !== 10'd9) begin
      errors++;
      $display("FAIL sync_idx: got %0d want 9", idx);
    end
  endtask

  task automatic test_back_to_back_gaps();
    logic [15:0] pat [3];
    logic [3:0]  es  [3];
    logic [4:0]  el  [3];
    logic f, se0, se1;
    logic [3:0] s;
    logic [4:0] l;
    logic [9:0] idx;
    pat[0] = 16'b0011001110000000; es[0] = 6; el[0] = 3;
    pat[1] = 16'b1110000111000000; es[1] = 0; el[1] = 3;
    pat[2] = 16'b0011011100000000; es[2] = 2; el[2] = 6;
    for (int k = 0; k < 3; k++) begin
      send_line(pat[k], 1'b1, f, s, l, idx, se0, se1);
      checks++;
      if (f !== 1'b1 || s !== es[k] || l !== el[k] || idx !== 10'(10 + k)) begin
        errors++;
        $display("FAIL gap_line%0d: got found=%b start=%0d len=%0d idx=%0d want 1/%0d/%0d/%0d",
                 k, f, s, l, idx, es[k], el[k], 10 + k);
      end
    end
  endtask

  task automatic test_hold();
    repeat (3) idle_cycle();
    checks++;
    if (bus.run_found !== 1'b1 || bus.run_start !== 4'd2 || bus.run_len !== 5'd6 ||
        bus.line_idx !== 10'd12) begin
      errors++;
      $display("FAIL record_hold: got found=%b start=%0d len=%0d idx=%0d want 1/2/6/12",
               bus.run_found, bus.run_start, bus.run_len, bus.line_idx);
    end
  endtask

  task automatic test_reset_midline();
    logic f, se0, se1;
    logic [3:0] s;
    logic [4:0] l;
    logic [9:0] idx;
    send_partial(16'hFFFF, 9);
    bus.pix_valid = 1'b1;
    bus.pix       = 1'b1;
    bus.sol       = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.run_found !== 1'b0 || bus.run_start !== 4'd0 || bus.run_len !== 5'd0 ||
        bus.line_idx !== 10'd0 || bus.out_valid !== 1'b0 || bus.sync_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got found=%b start=%0d len=%0d idx=%0d valid=%b serr=%b want all 0",
               bus.run_found, bus.run_start, bus.run_len, bus.line_idx,
               bus.out_valid, bus.sync_err);
    end
    bus.pix_valid = 1'b0;
    @(posedge CLK); #1;
    reset_n = 1'b1;
    send_line(16'b0000111100000000, 1'b0, f, s, l, idx, se0, se1);
    checks++;
    if (f !== 1'b1 || s !== 4'd4 || l !== 5'd4 || idx !== 10'd0 || se0 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_line: got found=%b start=%0d len=%0d idx=%0d serr=%b want 1/4/4/0/0",
               f, s, l, idx, se0);
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_lines();
    test_sync();
    test_back_to_back_gaps();
    test_hold();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
